host_cmd_loader: RTL and testbench

- Host-side command front end that decodes the 32-bit host word.
- Fills the 19-bit input memory through its write port, and starts and aborts the network run.
- Latches the classification result when the output layer reports settled.
- Returns a 32-bit status word to the host, and sits between the host bus and the memory/network/output_layer chain.

---
 rtl/host_cmd_pkg.sv | 35 +++
 rtl/host_cmd_loader_cmd_capture.sv | 37 +++
 rtl/host_cmd_loader.sv | 173 +++++++++++++++++
 tb/tb_host_cmd_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_pkg.sv
// Shared definitions for the host command loader: opcodes, FSM states,
// error codes and the bit layout of the status word returned to the host.
package host_cmd_pkg;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_CLEAR  = 4'd1;
    localparam logic [3:0] OP_WRITE  = 4'd2;
    localparam logic [3:0] OP_RUN    = 4'd3;
    localparam logic [3:0] OP_STATUS = 4'd4;
    localparam logic [3:0] OP_ABORT  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_ORDER     = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFILL = 2'd2,
        ERR_BUSY      = 2'd3
    } err_t;

    // Status word field positions
    localparam int ACK_BIT   = 31;
    localparam int STATE_LSB = 29;
    localparam int ERR_BIT   = 28;
    localparam int CODE_LSB  = 26;
    localparam int CNT_LSB   = 18;
    localparam int RES_LSB   = 14;
    localparam int TAG_LSB   = 6;

endpackage

// File: rtl/host_cmd_loader_cmd_capture.sv
// Registers the raw host word and detects a new command by comparing the
// host toggle bit against the last acknowledged toggle.
module cmd_capture #(
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_in,
    output logic              cmd_valid,
    output logic              tog,
    output logic [3:0]        opcode,
    output logic [7:0]        tag,
    output logic [DATA_W-1:0] payload
);

    logic [31:0] din_q;
    logic        tog_q;

    // Sample the host word every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_q <= '0;
        else     din_q <= data_in;
    end

    // Track the acknowledged toggle so each host toggle executes exactly once
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            tog_q <= 1'b0;
        else if (cmd_valid) tog_q <= din_q[31];
    end

    assign cmd_valid = din_q[31] != tog_q;
    assign tog       = tog_q;
    assign opcode    = din_q[30:27];
    assign tag       = din_q[26:19];
    assign payload   = din_q[DATA_W-1:0];

endmodule

// File: rtl/host_cmd_loader.sv
// Host command front end: fills the input memory, starts/aborts the network
// run, latches the settled classification result and reports status.
module host_cmd_loader
    import host_cmd_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 128,
    parameter int CNT_W  = 8,
    parameter int RES_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       data_in,
    input  logic              settled,
    input  logic [RES_W-1:0]  result,
    output logic              mem_clr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              run,
    output logic [31:0]       data_out
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic              cmd_valid;
    logic              tog;
    logic [3:0]        opcode;
    logic [7:0]        tag;
    logic [DATA_W-1:0] payload;
    logic              abort_now;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    err_t              code_q;
    logic [RES_W-1:0]  res_q;
    logic [7:0]        tag_q;

    cmd_capture #(.DATA_W(DATA_W)) u_capture (
        .clk       (clk),
        .rst       (rstn),
        .data_in   (data_in),
        .cmd_valid (cmd_valid),
        .tog       (tog),
        .opcode    (opcode),
        .tag       (tag),
        .payload   (payload)
    );

    assign abort_now = cmd_valid && (opcode == OP_ABORT);

    // Command FSM: memory fill, run control, error tracking, result latch
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            run         <= 1'b0;
            mem_clr     <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            err_q       <= 1'b0;
            code_q      <= ERR_ORDER;
            res_q       <= '0;
            tag_q       <= '0;
        end else begin
            mem_clr     <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;

            // A simultaneous ABORT takes priority over the settle event
            if (state == ST_RUN && settled && !abort_now) begin
                res_q <= result;
                run   <= 1'b0;
                state <= ST_DONE;
            end

            if (cmd_valid) begin
                tag_q <= tag;
                case (opcode)
                    OP_NOP: ;
                    OP_STATUS: begin
                        err_q  <= 1'b0;
                        code_q <= ERR_ORDER;
                    end
                    OP_CLEAR: begin
                        if (state == ST_RUN) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_BUSY;
                        end else begin
                            mem_clr <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_LOAD;
                        end
                    end
                    OP_WRITE: begin
                        case (state)
                            ST_LOAD: begin
                                if (cnt < DEPTH_C) begin
                                    mem_wr_en   <= 1'b1;
                                    mem_wr_data <= payload;
                                    cnt         <= cnt + CNT_W'(1);
                                end else begin
                                    err_q  <= 1'b1;
                                    code_q <= ERR_OVERFLOW;
                                end
                            end
                            ST_RUN: begin
                                err_q  <= 1'b1;
                                code_q <= ERR_BUSY;
                            end
                            default: begin
                                err_q  <= 1'b1;
                                code_q <= ERR_ORDER;
                            end
                        endcase
                    end
                    OP_RUN: begin
                        case (state)
                            ST_LOAD: begin
                                if (cnt == DEPTH_C) begin
                                    run   <= 1'b1;
                                    state <= ST_RUN;
                                end else begin
                                    err_q  <= 1'b1;
                                    code_q <= ERR_UNDERFILL;
                                end
                            end
                            ST_DONE: begin
                                run   <= 1'b1;
                                state <= ST_RUN;
                            end
                            ST_RUN: begin
                                err_q  <= 1'b1;
                                code_q <= ERR_BUSY;
                            end
                            default: begin
                                err_q  <= 1'b1;
                                code_q <= ERR_ORDER;
                            end
                        endcase
                    end
                    OP_ABORT: begin
                        case (state)
                            ST_RUN: begin
                                run   <= 1'b0;
                                state <= ST_IDLE;
                            end
                            ST_DONE: state <= ST_IDLE;
                            default: ;
                        endcase
                    end
                    default: begin
                        err_q  <= 1'b1;
                        code_q <= ERR_BUSY;
                    end
                endcase
            end
        end
    end

    // Status word assembled purely from registered fields
    always_comb begin
        data_out                         = '0;
        data_out[ACK_BIT]                = tog;
        data_out[STATE_LSB +: 2]         = state;
        data_out[ERR_BIT]                = err_q;
        data_out[CODE_LSB +: 2]          = code_q;
        data_out[CNT_LSB +: CNT_W]       = cnt;
        data_out[RES_LSB +: RES_W]       = res_q;
        data_out[TAG_LSB +: 8]           = tag_q;
    end

endmodule

// File: tb/tb_host_cmd_loader.sv
// Directed self-checking bench for host_cmd_loader.
module tb_host_cmd_loader;

    logic        clk;
    logic        rstn;
    logic [31:0] data_in;
    logic        settled;
    logic [3:0]  result;
    logic        mem_clr;
    logic        mem_wr_en;
    logic [18:0] mem_wr_data;
    logic        run;
    logic [31:0] data_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        tgl = 1'b0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    host_cmd_loader #(
        .DATA_W (19),
        .DEPTH  (128),
        .CNT_W  (8),
        .RES_W  (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .data_in     (data_in),
        .settled     (settled),
        .result      (result),
        .mem_clr     (mem_clr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .run         (run),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] st(input logic t, input logic [1:0] s,
                                       input logic e, input logic [1:0] c,
                                       input logic [7:0] n, input logic [3:0] r,
                                       input logic [7:0] g);
        return {t, s, e, c, n, r, g, 6'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Issue one command right after an edge; returns #1 after the edge where
    // its effects become visible (two edges later).
    task automatic send(input logic [3:0] op, input logic [7:0] tg, input logic [18:0] pl,
                        input logic settle_mid, input logic [3:0] sres);
        tgl     = ~tgl;
        data_in = {tgl, op, tg, pl};
        @(posedge clk); #1;
        chk("early_wr", {31'b0, mem_wr_en}, 32'd0);
        chk("early_clr", {31'b0, mem_clr}, 32'd0);
        if (settle_mid) begin
            settled = 1'b1;
            result  = sres;
        end
        @(posedge clk); #1;
        settled = 1'b0;
        chk("ack", {31'b0, data_out[31]}, {31'b0, tgl});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn    = 1'b1;
        data_in = {1'b0, 4'd1, 8'h33, 19'h0};
        settled = 1'b0;
        result  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", data_out, 32'd0);
        chk("rst_run", {31'b0, run}, 32'd0);
        chk("rst_wr", {31'b0, mem_wr_en}, 32'd0);
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("idle_clr", {31'b0, mem_clr}, 32'd0);
        end
        chk("idle_dout", data_out, 32'd0);

        // Full frame
        send(4'd1, 8'h01, 19'd0, 1'b0, 4'd0);
        chk("clr_pulse", {31'b0, mem_clr}, 32'd1);
        chk("clr_stat", data_out, st(tgl, S_LOAD, 1'b0, 2'd0, 8'd0, 4'd0, 8'h01));
        for (int i = 0; i < 128; i++) begin
            send(4'd2, 8'h02, 19'(i), 1'b0, 4'd0);
            chk("wr_en", {31'b0, mem_wr_en}, 32'd1);
            chk("wr_data", {13'b0, mem_wr_data}, i);
        end
        chk("full_stat", data_out, st(tgl, S_LOAD, 1'b0, 2'd0, 8'h80, 4'd0, 8'h02));

        // Overflow then STATUS
        send(4'd2, 8'h03, 19'h7FFFF, 1'b0, 4'd0);
        chk("ovf_wr", {31'b0, mem_wr_en}, 32'd0);
        chk("ovf_data", {13'b0, mem_wr_data}, 32'd0);
        chk("ovf_stat", data_out, st(tgl, S_LOAD, 1'b1, 2'd1, 8'h80, 4'd0, 8'h03));
        send(4'd4, 8'h04, 19'd0, 1'b0, 4'd0);
        chk("status_clr", data_out, st(tgl, S_LOAD, 1'b0, 2'd0, 8'h80, 4'd0, 8'h04));

        // Run and settle
        send(4'd3, 8'h5A, 19'd0, 1'b0, 4'd0);
        chk("run_on", {31'b0, run}, 32'd1);
        chk("run_stat", data_out, st(tgl, S_RUN, 1'b0, 2'd0, 8'h80, 4'd0, 8'h5A));
        repeat (3) @(posedge clk);
        #1;
        chk("run_hold", {31'b0, run}, 32'd1);
        settled = 1'b1;
        result  = 4'd7;
        @(posedge clk); #1;
        settled = 1'b0;
        result  = 4'd0;
        chk("settle_run", {31'b0, run}, 32'd0);
        chk("done_stat", data_out, st(tgl, S_DONE, 1'b0, 2'd0, 8'h80, 4'd7, 8'h5A));

        // Re-run, then ABORT coinciding with settled
        send(4'd3, 8'h06, 19'd0, 1'b0, 4'd0);
        chk("rerun_on", {31'b0, run}, 32'd1);
        chk("rerun_stat", data_out, st(tgl, S_RUN, 1'b0, 2'd0, 8'h80, 4'd7, 8'h06));
        send(4'd5, 8'h0B, 19'd0, 1'b1, 4'd9);
        chk("abort_run", {31'b0, run}, 32'd0);
        chk("abort_stat", data_out, st(tgl, S_IDLE, 1'b0, 2'd0, 8'h80, 4'd7, 8'h0B));

        // Underfill
        send(4'd1, 8'h10, 19'd0, 1'b0, 4'd0);
        chk("clr2_pulse", {31'b0, mem_clr}, 32'd1);
        chk("clr2_stat", data_out, st(tgl, S_LOAD, 1'b0, 2'd0, 8'd0, 4'd7, 8'h10));
        for (int i = 0; i < 3; i++) begin
            send(4'd2, 8'h12, 19'h7FFF0 + 19'(i), 1'b0, 4'd0);
            chk("uf_wr_data", {13'b0, mem_wr_data}, 32'h7FFF0 + i);
        end
        send(4'd3, 8'h11, 19'd0, 1'b0, 4'd0);
        chk("uf_run", {31'b0, run}, 32'd0);
        chk("uf_stat", data_out, st(tgl, S_LOAD, 1'b1, 2'd2, 8'd3, 4'd7, 8'h11));

        // Async reset mid-LOAD while a write pulse is up
        send(4'd4, 8'h13, 19'd0, 1'b0, 4'd0);
        send(4'd1, 8'h14, 19'd0, 1'b0, 4'd0);
        for (int i = 0; i < 40; i++) send(4'd2, 8'h15, 19'(i), 1'b0, 4'd0);
        chk("cnt40_stat", data_out, st(tgl, S_LOAD, 1'b0, 2'd0, 8'd40, 4'd7, 8'h15));
        send(4'd2, 8'h15, 19'h1234, 1'b0, 4'd0);
        chk("pre_rst_wr", {31'b0, mem_wr_en}, 32'd1);
        #2;
        rstn    = 1'b1;
        tgl     = 1'b0;
        data_in = 32'd0;
        #1;
        chk("arst_dout", data_out, 32'd0);
        chk("arst_wr", {31'b0, mem_wr_en}, 32'd0);
        chk("arst_data", {13'b0, mem_wr_data}, 32'd0);
        chk("arst_run", {31'b0, run}, 32'd0);
        chk("arst_clr", {31'b0, mem_clr}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        send(4'd2, 8'h20, 19'd5, 1'b0, 4'd0);
        chk("order_wr", {31'b0, mem_wr_en}, 32'd0);
        chk("order_stat", data_out, st(1'b1, S_IDLE, 1'b1, 2'd0, 8'd0, 4'd0, 8'h20));

        // Illegal opcode reports BUSY, STATUS clears it
        send(4'hC, 8'h21, 19'd0, 1'b0, 4'd0);
        chk("illegal_stat", data_out, st(1'b0, S_IDLE, 1'b1, 2'd3, 8'd0, 4'd0, 8'h21));
        send(4'd4, 8'h22, 19'd0, 1'b0, 4'd0);
        chk("final_stat", data_out, st(1'b1, S_IDLE, 1'b0, 2'd0, 8'd0, 4'd0, 8'h22));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
